mem_req_arbiter: RTL and testbench

Shares the single cache-line AXI master between icache refill, dcache refill and dcache write-back.

---
 rtl/mem_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache refill, dcache refill and dcache write-back onto one AXI line master.
// It moves one line per transaction as LINE_WORDS 32-bit beats.
module mem_req_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_ren_i,
  input  logic [31:0]              inst_addr_i,
  input  logic                     inst_abort_i,
  output logic                     inst_rvalid_o,
  input  logic                     data_ren_i,
  input  logic [31:0]              data_raddr_i,
  output logic                     data_rvalid_o,
  output logic [32*LINE_WORDS-1:0] line_rdata_o,
  input  logic                     data_wen_i,
  input  logic [31:0]              data_waddr_i,
  input  logic [32*LINE_WORDS-1:0] data_wdata_i,
  output logic                     data_bvalid_o,
  output logic                     dev_rrdy_o,
  output logic                     dev_wrdy_o,
  output logic [7:0]               axi_len_o,
  output logic                     axi_ren_o,
  output logic [31:0]              axi_raddr_o,
  input  logic                     axi_arready_i,
  input  logic [31:0]              axi_rdata_i,
  input  logic                     axi_rvalid_i,
  output logic                     axi_wen_o,
  output logic [31:0]              axi_waddr_o,
  input  logic                     axi_awready_i,
  output logic [31:0]              axi_wdata_o,
  output logic                     axi_wvalid_o,
  output logic                     axi_wlast_o,
  input  logic                     axi_wready_i,
  input  logic                     axi_bvalid_i
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(LINE_WORDS - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, RDONE, WADDR, WDATA, WRESP} state_t;
  typedef enum logic [1:0] {REQ_INST, REQ_DREAD, REQ_DWRITE} req_t;

  state_t                  state;
  req_t                    owner;
  logic [CW-1:0]           beat_cnt;
  logic [SW-1:0]           starve_cnt;
  logic                    abort_flag;
  logic [32*LINE_WORDS-1:0] line_buf;
  logic [32*LINE_WORDS-1:0] wline;
  logic [32*LINE_WORDS-1:0] assembled;
  logic                    inst_wins;
  logic                    inst_owned;

  assign inst_wins  = inst_ren_i && (starve_cnt == STARVE_LIM);
  assign inst_owned = (owner == REQ_INST);

  always_comb begin
    assembled = line_buf;
    assembled[32*int'(beat_cnt) +: 32] = axi_rdata_i;
  end

  assign axi_len_o   = 8'(LINE_WORDS - 1);
  assign dev_rrdy_o  = (state == IDLE);
  assign dev_wrdy_o  = (state == IDLE);
  assign axi_wdata_o = wline[32*int'(beat_cnt) +: 32];
  assign axi_wlast_o = axi_wvalid_o && (beat_cnt == LAST_BEAT);

  // The write-back ack follows bvalid directly, so the dcache drops its request
  // on the same edge that we return to IDLE and cannot be granted twice.
  assign data_bvalid_o = (state == WRESP) && axi_bvalid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= REQ_INST;
      beat_cnt      <= '0;
      starve_cnt    <= '0;
      abort_flag    <= 1'b0;
      line_buf      <= '0;
      wline         <= '0;
      line_rdata_o  <= '0;
      axi_raddr_o   <= '0;
      axi_waddr_o   <= '0;
      axi_ren_o     <= 1'b0;
      axi_wen_o     <= 1'b0;
      axi_wvalid_o  <= 1'b0;
      inst_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abort_flag <= 1'b0;
          beat_cnt   <= '0;
          if (data_wen_i && !inst_wins) begin
            owner       <= REQ_DWRITE;
            axi_waddr_o <= data_waddr_i;
            wline       <= data_wdata_i;
            axi_wen_o   <= 1'b1;
            state       <= WADDR;
            if (inst_ren_i) starve_cnt <= starve_cnt + 1'b1;
          end else if (data_ren_i && !inst_wins) begin
            owner       <= REQ_DREAD;
            axi_raddr_o <= data_raddr_i;
            axi_ren_o   <= 1'b1;
            state       <= RADDR;
            if (inst_ren_i) starve_cnt <= starve_cnt + 1'b1;
          end else if (inst_ren_i) begin
            owner       <= REQ_INST;
            axi_raddr_o <= inst_addr_i;
            axi_ren_o   <= 1'b1;
            state       <= RADDR;
            starve_cnt  <= '0;
          end
        end
        RADDR: begin
          if (inst_abort_i && inst_owned) abort_flag <= 1'b1;
          if (axi_arready_i) begin
            axi_ren_o <= 1'b0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (inst_abort_i && inst_owned) abort_flag <= 1'b1;
          if (axi_rvalid_i) begin
            line_buf <= assembled;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt      <= '0;
              line_rdata_o  <= assembled;
              inst_rvalid_o <= inst_owned && !abort_flag && !inst_abort_i;
              data_rvalid_o <= (owner == REQ_DREAD);
              state         <= RDONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RDONE: begin
          inst_rvalid_o <= 1'b0;
          data_rvalid_o <= 1'b0;
          abort_flag    <= 1'b0;
          state         <= IDLE;
        end
        WADDR: begin
          if (axi_awready_i) begin
            axi_wen_o    <= 1'b0;
            axi_wvalid_o <= 1'b1;
            state        <= WDATA;
          end
        end
        WDATA: begin
          if (axi_wready_i) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt     <= '0;
              axi_wvalid_o <= 1'b0;
              state        <= WRESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WRESP: begin
          if (axi_bvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a line-vector table plus hand-written
// sequences for arbitration order, starvation, abort and mid-burst reset.
module tb_mem_req_arbiter;

  localparam int KIND_INST  = 0;
  localparam int KIND_DREAD = 1;
  localparam int KIND_WRITE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         inst_ren_i, inst_abort_i, inst_rvalid_o;
  logic [31:0]  inst_addr_i;
  logic         data_ren_i, data_rvalid_o;
  logic [31:0]  data_raddr_i;
  logic [127:0] line_rdata_o;
  logic         data_wen_i, data_bvalid_o;
  logic [31:0]  data_waddr_i;
  logic [127:0] data_wdata_i;
  logic         dev_rrdy_o, dev_wrdy_o;
  logic [7:0]   axi_len_o;
  logic         axi_ren_o, axi_arready_i, axi_rvalid_i;
  logic [31:0]  axi_raddr_o, axi_rdata_i;
  logic         axi_wen_o, axi_awready_i, axi_wvalid_o, axi_wlast_o, axi_wready_i, axi_bvalid_i;
  logic [31:0]  axi_waddr_o, axi_wdata_o;

  always #5 clk = ~clk;

  mem_req_arbiter #(.LINE_WORDS(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_addr_i(inst_addr_i), .inst_abort_i(inst_abort_i),
    .inst_rvalid_o(inst_rvalid_o),
    .data_ren_i(data_ren_i), .data_raddr_i(data_raddr_i), .data_rvalid_o(data_rvalid_o),
    .line_rdata_o(line_rdata_o),
    .data_wen_i(data_wen_i), .data_waddr_i(data_waddr_i), .data_wdata_i(data_wdata_i),
    .data_bvalid_o(data_bvalid_o),
    .dev_rrdy_o(dev_rrdy_o), .dev_wrdy_o(dev_wrdy_o), .axi_len_o(axi_len_o),
    .axi_ren_o(axi_ren_o), .axi_raddr_o(axi_raddr_o), .axi_arready_i(axi_arready_i),
    .axi_rdata_i(axi_rdata_i), .axi_rvalid_i(axi_rvalid_i),
    .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wvalid_o(axi_wvalid_o), .axi_wlast_o(axi_wlast_o),
    .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] last_line = '0;

  typedef struct {
    int           kind;
    logic [31:0]  req_addr;
    logic [127:0] beats;
    bit           slow;
    logic [31:0]  exp_addr;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs[5];

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Plays the AXI read slave and the requesting cache for one line read.
  task automatic serve_read(input int kind, input logic [31:0] exp_addr, input logic [127:0] beats,
                            input logic [127:0] exp_line, input bit slow, input int abort_beat,
                            input bit expect_pulse, input string tag);
    int waited = 0;
    logic [1:0] exp_pulse;
    while (!axi_ren_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val($sformatf("%s arvalid", tag), 128'(axi_ren_o), 128'(1));
    if (!axi_ren_o) return;
    check_val($sformatf("%s araddr", tag), 128'(axi_raddr_o), 128'(exp_addr));
    axi_arready_i = 1'b1;
    @(negedge clk);
    axi_arready_i = 1'b0;
    check_val($sformatf("%s arvalid drop", tag), 128'({axi_ren_o, dev_rrdy_o}), 128'(0));
    for (int i = 0; i < 4; i++) begin
      if (slow && i > 0) @(negedge clk);
      axi_rdata_i  = beats[32*i +: 32];
      axi_rvalid_i = 1'b1;
      inst_abort_i = (i == abort_beat);
      @(negedge clk);
      axi_rvalid_i = 1'b0;
      inst_abort_i = 1'b0;
    end
    exp_pulse = !expect_pulse ? 2'b00 : (kind == KIND_INST) ? 2'b10 : 2'b01;
    check_val($sformatf("%s pulse", tag), 128'({inst_rvalid_o, data_rvalid_o}), 128'(exp_pulse));
    if (expect_pulse) check_val($sformatf("%s line", tag), line_rdata_o, exp_line);
    if (kind == KIND_INST) inst_ren_i = 1'b0;
    else data_ren_i = 1'b0;
    @(negedge clk);
    check_val($sformatf("%s pulse end", tag), 128'({inst_rvalid_o, data_rvalid_o, dev_rrdy_o}), 128'(1));
  endtask

  // Plays the AXI write slave for one write-back; slow toggles wready every cycle.
  task automatic serve_write(input logic [31:0] exp_addr, input logic [127:0] exp_line,
                             input bit slow, input string tag);
    int waited = 0;
    int beat = 0;
    bit phase = 1'b0;
    bit rdy;
    while (!axi_wen_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val($sformatf("%s awvalid", tag), 128'(axi_wen_o), 128'(1));
    if (!axi_wen_o) return;
    check_val($sformatf("%s awaddr", tag), 128'(axi_waddr_o), 128'(exp_addr));
    axi_awready_i = 1'b1;
    @(negedge clk);
    axi_awready_i = 1'b0;
    check_val($sformatf("%s awvalid drop", tag), 128'(axi_wen_o), 128'(0));
    waited = 0;
    while (beat < 4 && waited < 50) begin
      rdy   = slow ? phase : 1'b1;
      phase = ~phase;
      if (rdy && axi_wvalid_o) begin
        check_val($sformatf("%s beat%0d", tag, beat), 128'({axi_wlast_o, axi_wdata_o}),
                  128'({beat == 3, exp_line[32*beat +: 32]}));
        beat++;
      end
      axi_wready_i = rdy;
      @(negedge clk);
      waited++;
    end
    axi_wready_i = 1'b0;
    check_val($sformatf("%s beat count", tag), 128'(beat), 128'(4));
    check_val($sformatf("%s wvalid drop", tag), 128'({axi_wvalid_o, data_bvalid_o}), 128'(0));
    @(negedge clk);
    axi_bvalid_i = 1'b1;
    #1;
    check_val($sformatf("%s bvalid", tag), 128'(data_bvalid_o), 128'(1));
    data_wen_i = 1'b0;
    @(negedge clk);
    axi_bvalid_i = 1'b0;
    #1;
    check_val($sformatf("%s bvalid end", tag), 128'({data_bvalid_o, dev_wrdy_o}), 128'(1));
  endtask

  task automatic apply_stimulus(input vec_t v);
    case (v.kind)
      KIND_INST: begin
        inst_addr_i = v.req_addr;
        inst_ren_i  = 1'b1;
      end
      KIND_DREAD: begin
        data_raddr_i = v.req_addr;
        data_ren_i   = 1'b1;
      end
      default: begin
        data_waddr_i = v.req_addr;
        data_wdata_i = v.beats;
        data_wen_i   = 1'b1;
      end
    endcase
  endtask

  task automatic check_output(input vec_t v, input string tag);
    if (v.kind == KIND_WRITE) begin
      serve_write(v.exp_addr, v.exp_line, v.slow, tag);
      check_val($sformatf("%s line held", tag), line_rdata_o, last_line);
    end else begin
      serve_read(v.kind, v.exp_addr, v.beats, v.exp_line, v.slow, -1, 1'b1, tag);
      last_line = v.exp_line;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    rst = 1'b1;
    inst_ren_i = 1'b0; inst_abort_i = 1'b0; inst_addr_i = 32'hBAD0_0001;
    data_ren_i = 1'b0; data_raddr_i = 32'hBAD0_0002;
    data_wen_i = 1'b0; data_waddr_i = 32'hBAD0_0003; data_wdata_i = '0;
    axi_arready_i = 1'b0; axi_rdata_i = '0; axi_rvalid_i = 1'b0;
    axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0;

    vecs[0] = '{KIND_INST,  32'h1C00_0000, 128'h00000004_00000003_00000002_00000001, 1'b0,
                32'h1C00_0000, 128'h00000004_00000003_00000002_00000001};
    vecs[1] = '{KIND_WRITE, 32'h8000_1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1,
                32'h8000_1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
    vecs[2] = '{KIND_DREAD, 32'h8000_2040, 128'hCAFEBABE_DEADBEEF_12345678_9ABCDEF0, 1'b0,
                32'h8000_2040, 128'hCAFEBABE_DEADBEEF_12345678_9ABCDEF0};
    vecs[3] = '{KIND_WRITE, 32'h8000_3000, 128'h44444444_33333333_22222222_11111111, 1'b0,
                32'h8000_3000, 128'h44444444_33333333_22222222_11111111};
    vecs[4] = '{KIND_DREAD, 32'h0000_0FF0, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 1'b1,
                32'h0000_0FF0, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000};

    repeat (2) @(negedge clk);
    check_val("reset rdy", 128'({dev_rrdy_o, dev_wrdy_o}), 128'(2'b11));
    check_val("reset len", 128'(axi_len_o), 128'(8'd3));
    check_val("reset valids", 128'({axi_ren_o, axi_wen_o, axi_wvalid_o, axi_wlast_o}), 128'(0));
    check_val("reset pulses", 128'({inst_rvalid_o, data_rvalid_o, data_bvalid_o}), 128'(0));
    check_val("reset line", line_rdata_o, 128'(0));
    check_val("reset addrs", 128'({axi_raddr_o, axi_waddr_o}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], $sformatf("vec%0d", i));
    end

    // A stray rvalid while idle must not advance the beat counter.
    axi_rdata_i  = 32'hEEEE_EEEE;
    axi_rvalid_i = 1'b1;
    @(negedge clk);
    axi_rvalid_i = 1'b0;
    check_val("stray rvalid", 128'({dev_rrdy_o, inst_rvalid_o, data_rvalid_o}), 128'(3'b100));
    inst_addr_i = 32'h1C00_0040;
    inst_ren_i  = 1'b1;
    serve_read(KIND_INST, 32'h1C00_0040, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A,
               128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b0, -1, 1'b1, "after stray");

    // All three requesters at once: write, then dcache read, then icache read.
    data_waddr_i = 32'h8000_4000; data_wdata_i = 128'h00000404_00000303_00000202_00000101;
    data_raddr_i = 32'h8000_5000; inst_addr_i = 32'h1C00_0080;
    data_wen_i = 1'b1; data_ren_i = 1'b1; inst_ren_i = 1'b1;
    serve_write(32'h8000_4000, 128'h00000404_00000303_00000202_00000101, 1'b0, "triple wr");
    serve_read(KIND_DREAD, 32'h8000_5000, 128'h55555555_66666666_77777777_88888888,
               128'h55555555_66666666_77777777_88888888, 1'b0, -1, 1'b1, "triple dr");
    serve_read(KIND_INST, 32'h1C00_0080, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC,
               128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 1'b0, -1, 1'b1, "triple ir");

    // Held icache request wins once four dcache grants went by.
    inst_addr_i = 32'h1C00_0100;
    inst_ren_i  = 1'b1;
    for (int g = 0; g < 4; g++) begin
      data_raddr_i = 32'h8000_6000 + 32'(g * 64);
      data_ren_i   = 1'b1;
      serve_read(KIND_DREAD, 32'h8000_6000 + 32'(g * 64), {4{32'h0000_0D00 + 32'(g)}},
                 {4{32'h0000_0D00 + 32'(g)}}, 1'b0, -1, 1'b1, $sformatf("starve d%0d", g));
    end
    data_raddr_i = 32'h8000_7000;
    data_ren_i   = 1'b1;
    serve_read(KIND_INST, 32'h1C00_0100, 128'h11112222_33334444_55556666_77778888,
               128'h11112222_33334444_55556666_77778888, 1'b0, -1, 1'b1, "starve icache");
    serve_read(KIND_DREAD, 32'h8000_7000, 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0,
               128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0, 1'b0, -1, 1'b1, "starve tail");

    // Abort mid-burst suppresses the pulse; abort while idle is ignored.
    inst_addr_i = 32'h1C00_0200;
    inst_ren_i  = 1'b1;
    serve_read(KIND_INST, 32'h1C00_0200, 128'h12121212_34343434_56565656_78787878,
               128'h0, 1'b0, 2, 1'b0, "aborted");
    inst_addr_i  = 32'h1C00_0300;
    inst_ren_i   = 1'b1;
    inst_abort_i = 1'b1;
    @(negedge clk);
    inst_abort_i = 1'b0;
    serve_read(KIND_INST, 32'h1C00_0300, 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4,
               128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4, 1'b0, -1, 1'b1, "after abort");

    // Reset during beat 2 of a dcache read.
    data_raddr_i = 32'h8000_8000;
    data_ren_i   = 1'b1;
    for (int c = 0; c < 50 && !axi_ren_o; c++) @(negedge clk);
    check_val("rst-mid arvalid", 128'(axi_ren_o), 128'(1));
    axi_arready_i = 1'b1;
    @(negedge clk);
    axi_arready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi_rdata_i  = 32'h5A5A_0000 + 32'(i);
      axi_rvalid_i = 1'b1;
      @(negedge clk);
    end
    axi_rdata_i = 32'h5A5A_0002;
    rst = 1'b1;
    #1;
    check_val("rst-mid outputs", 128'({dev_rrdy_o, dev_wrdy_o, axi_ren_o, data_rvalid_o, inst_rvalid_o}),
              128'(5'b11000));
    check_val("rst-mid line", line_rdata_o, 128'(0));
    data_ren_i = 1'b0;
    @(negedge clk);
    axi_rvalid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst-mid no pulse", 128'({data_rvalid_o, inst_rvalid_o, dev_rrdy_o}), 128'(3'b001));
    data_raddr_i = 32'h8000_9000;
    data_ren_i   = 1'b1;
    serve_read(KIND_DREAD, 32'h8000_9000, 128'h87654321_0FEDCBA9_13572468_ACEBDF00,
               128'h87654321_0FEDCBA9_13572468_ACEBDF00, 1'b0, -1, 1'b1, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
